// File: rtl/iobuf_pkg.sv
// iobuf_pkg: shared types and limits for the iobuf sequencer.
//   state_t   sequencer FSM states
//   io_cfg_t  one iobuf configuration {oe, od, dir, din}
package iobuf_pkg;
  typedef enum logic [2:0] {IDLE, PARK, WAIT_OFF, APPLY, WAIT_ON} state_t;
  typedef struct packed {
    logic oe;
    logic od;
    logic dir;
    logic din;
  } io_cfg_t;
  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 255;
endpackage

// File: rtl/iobuf_seq_sync2.sv
// sync2: two-flop synchroniser bringing an asynchronous bit into the clk domain.
//   clk  system clock
//   rst  asynchronous active-low reset, clears both flops
//   d_i  asynchronous input
//   q_o  synchronised output, two clk edges after d_i
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) {q_o, meta_q} <= 2'b00;
    else {q_o, meta_q} <= {meta_q, d_i};
endmodule

// File: rtl/iobuf_seq.sv
// iobuf_seq: break-before-make sequencer that applies oe/od/dir/din requests to one iobuf.
//   clk, rst                   clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake; req_oe/od/dir/din latched on accept
//   busy                       a direction/mode sequence is in progress (~req_ready)
//   io_oe/io_od/io_dir/io_din  registered drive to the iobuf
//   io_dout, pin_in            pin readback and its clk-domain synchronised copy
module iobuf_seq
  import iobuf_pkg::*;
#(
  parameter  int SETTLE_CYCLES = 4,
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  output logic req_ready,
  input  logic req_oe,
  input  logic req_od,
  input  logic req_dir,
  input  logic req_din,
  output logic busy,
  output logic io_oe,
  output logic io_od,
  output logic io_dir,
  output logic io_din,
  input  logic io_dout,
  output logic pin_in
);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(SETTLE_CYCLES - 1);
  if (SETTLE_CYCLES < SETTLE_MIN || SETTLE_CYCLES > SETTLE_MAX) begin : g_bad_settle
    $error("iobuf_seq: SETTLE_CYCLES out of range");
  end
  state_t           state_q;
  io_cfg_t          io_q, req_q, req;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, fast_q, accept, fast;
  assign req    = '{oe: req_oe, od: req_od, dir: req_dir, din: req_din};
  assign accept = req_valid & ~busy_q;
  // Only din differs: no buffer reconfiguration, so no Hi-Z window is needed.
  assign fast   = {req.oe, req.od, req.dir} == {io_q.oe, io_q.od, io_q.dir};
  // Requests are latched on the accept edge and acted on one edge later;
  // non-fast requests raise busy on the accept edge so nothing overlaps them.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      io_q    <= '0;
      req_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      fast_q  <= 1'b0;
    end else begin
      fast_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fast_q) io_q.din <= req_q.din;
          if (accept) begin
            req_q  <= req;
            fast_q <= fast;
            if (!fast) begin
              busy_q  <= 1'b1;
              state_q <= io_q.oe ? PARK : APPLY;
            end
          end
        end
        PARK: begin
          io_q.oe <= 1'b0;
          cnt_q   <= LOAD;
          state_q <= WAIT_OFF;
        end
        // The end of the off-settle applies the new mode exactly like a cold APPLY.
        WAIT_OFF, APPLY:
          if (state_q == WAIT_OFF && cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
          else begin
            io_q    <= '{oe: 1'b0, od: req_q.od, dir: req_q.dir, din: req_q.din};
            cnt_q   <= LOAD;
            state_q <= req_q.oe ? WAIT_ON : IDLE;
            busy_q  <= req_q.oe;
          end
        WAIT_ON:
          if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
          else begin
            io_q.oe <= 1'b1;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  assign {io_oe, io_od, io_dir, io_din} = io_q;
  assign busy      = busy_q;
  assign req_ready = ~busy_q;
  sync2 u_sync (.clk(clk), .rst(rst), .d_i(io_dout), .q_o(pin_in));
endmodule

// File: tb/tb_iobuf_seq.sv
// tb_iobuf_seq: randomized and directed checks of iobuf_seq against a timeline model.
module tb_iobuf_seq;
  localparam int S = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic req_valid = 1'b0, req_oe = 1'b0, req_od = 1'b0, req_dir = 1'b0, req_din = 1'b0;
  logic io_dout = 1'b0;
  logic req_ready, busy, io_oe, io_od, io_dir, io_din, pin_in;
  iobuf_seq #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_oe(req_oe), .req_od(req_od), .req_dir(req_dir), .req_din(req_din),
    .busy(busy), .io_oe(io_oe), .io_od(io_od), .io_dir(io_dir), .io_din(io_din),
    .io_dout(io_dout), .pin_in(pin_in)
  );
  always #5 clk = ~clk;
  typedef struct {int t; logic [3:0] m; logic [3:0] v;} ev_t;
  ev_t        evq[$];
  logic [3:0] mdl = '0;
  logic [1:0] p_oddir = '0;
  logic       p_oe = 1'b0, dp = 1'b0;
  int         e = 0, t_done = -1, n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
  endtask
  task automatic hard_reset();
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_io", {io_oe, io_od, io_dir, io_din}, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_pin", pin_in, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    mdl = '0;
    evq.delete();
    t_done = e;
    dp = 1'b0;
    p_oe = 1'b0;
    p_oddir = '0;
  endtask
  // One clock: drive at negedge, let the model react to the edge, check #1 later.
  task automatic cyc(input logic v, input logic [3:0] r, input logic d, output logic acc);
    req_valid = v;
    {req_oe, req_od, req_dir, req_din} = r;
    io_dout = d;
    @(posedge clk);
    e++;
    acc = v && e > t_done;
    if (acc) begin
      if (r[3:1] == mdl[3:1]) begin
        evq.push_back('{e + 1, 4'b0001, r});
        t_done = e;
      end else if (!mdl[3]) begin
        evq.push_back('{e + 1, 4'b1111, {1'b0, r[2:0]}});
        if (r[3]) evq.push_back('{e + 1 + S, 4'b1000, 4'b1000});
        t_done = r[3] ? e + 1 + S : e + 1;
      end else begin
        evq.push_back('{e + 1, 4'b1000, 4'b0000});
        evq.push_back('{e + 1 + S, 4'b1111, {1'b0, r[2:0]}});
        if (r[3]) evq.push_back('{e + 1 + 2 * S, 4'b1000, 4'b1000});
        t_done = r[3] ? e + 1 + 2 * S : e + 1 + S;
      end
    end
    for (int i = evq.size() - 1; i >= 0; i--)
      if (evq[i].t == e) begin
        mdl = (mdl & ~evq[i].m) | (evq[i].v & evq[i].m);
        evq.delete(i);
      end
    #1;
    chk("io", {io_oe, io_od, io_dir, io_din}, mdl);
    chk("busy", busy, e < t_done);
    chk("ready", req_ready, !(e < t_done));
    chk("pin_in", pin_in, dp);
    if ({io_od, io_dir} != p_oddir) chk("order_oe_low", io_oe, 1'b0);
    if (io_oe && !p_oe) chk("order_rise", {io_od, io_dir}, p_oddir);
    p_oe = io_oe;
    p_oddir = {io_od, io_dir};
    dp = d;
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) cyc(1'b0, 4'b0000, 1'b0, a);
  endtask
  initial begin
    logic       a, v;
    logic [3:0] r;
    logic [3:0] burst[4] = '{4'b1000, 4'b1001, 4'b1000, 4'b1001};
    hard_reset();
    idle(2);
    cyc(1'b1, 4'b1011, 1'b0, a);
    chk("cold_acc", a, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b0, 4'b0000, 1'b0, a);
      chk("cold_io", {io_oe, io_od, io_dir, io_din}, i >= 5 ? 4'b1011 : 4'b0011);
      chk("cold_busy", busy, i < 5);
    end
    cyc(1'b1, 4'b1000, 1'b0, a);
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b0, 4'b0000, 1'b0, a);
      chk("hot_io", {io_oe, io_od, io_dir, io_din},
          i >= 9 ? 4'b1000 : (i >= 5 ? 4'b0000 : 4'b0011));
    end
    for (int j = 0; j < 4; j++) begin
      cyc(1'b1, burst[j], 1'b0, a);
      chk("fast_acc", a, 1'b1);
      chk("fast_oe", io_oe, 1'b1);
      if (j > 0) chk("fast_din", io_din, burst[j-1][0]);
    end
    idle(1);
    chk("fast_last", io_din, 1'b1);
    cyc(1'b1, 4'b1101, 1'b0, a);
    idle(10);
    chk("od_final", {io_oe, io_od, io_dir, io_din}, 4'b1101);
    cyc(1'b1, 4'b0000, 1'b0, a);
    idle(6);
    chk("dis_final", {io_oe, io_od, io_dir, io_din}, 4'b0000);
    cyc(1'b1, 4'b1011, 1'b0, a);
    idle(6);
    cyc(1'b1, 4'b1000, 1'b0, a);
    idle(3);
    chk("midseq_busy", busy, 1'b1);
    hard_reset();
    idle(12);
    chk("no_resume", {io_oe, io_od, io_dir, io_din}, 4'b0000);
    idle(2);
    cyc(1'b0, 4'b0000, 1'b1, a);
    chk("pin_lat1", pin_in, 1'b0);
    cyc(1'b0, 4'b0000, 1'b1, a);
    chk("pin_lat2", pin_in, 1'b1);
    v = 1'b0;
    a = 1'b0;
    r = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        hard_reset();
        v = 1'b0;
      end
      if (!v || a) begin
        v = $urandom_range(0, 2) != 0;
        r = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 1) r = {mdl[3:1], r[0]};
      end
      cyc(v, r, 1'($urandom_range(0, 1)), a);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/iobuf_seq.md
Name: iobuf_seq

Overview:
- Sequencer sitting between the Bus Pirate protocol engines and one iobuf instance.
- Accepts IO configuration requests (oe/od/dir/din) over a valid/ready handshake.
- Applies each request to iobuf with a break-before-make sequence, so the 74LVC1T45 direction or 74LVC1G07 open-drain mode never changes while the pin is driven.
- Synchronises the pin readback (iobuf dout) into the clk domain.

Parameters:
- SETTLE_CYCLES, 4: clk cycles of Hi-Z hold before and after a direction/mode change; legal range 1..255.
- CNT_W, $clog2(SETTLE_CYCLES+1): settle counter width (derived; do not override).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  request strobe
- req_ready  out  1  high when a request can be accepted
- req_oe  in  1  requested output enable (1=drive)
- req_od  in  1  requested open-drain mode (1=open drain)
- req_dir  in  1  requested buffer direction
- req_din  in  1  requested output data
- busy  out  1  sequence in progress (equals ~req_ready)
- io_oe  out  1  to iobuf oe
- io_od  out  1  to iobuf od
- io_dir  out  1  to iobuf dir
- io_din  out  1  to iobuf din
- io_dout  in  1  from iobuf dout (asynchronous to clk)
- pin_in  out  1  io_dout after a 2-flop synchroniser

Behaviour:
- Reset (rst=0, async):
  - io_oe=0, io_od=0, io_dir=0, io_din=0, pin_in=0.
  - State IDLE, req_ready=1, busy=0, counter=0.
  - Reset asserted mid-sequence parks the pin immediately; no sequence resumes after release.
- Handshake:
  - Accept on a clk edge where req_valid & req_ready; all req_* fields are latched at that edge only.
  - req_valid while busy is ignored; the requester holds it until accepted.
- Classification at accept, comparing latched request against current io_*:
  - FAST: oe, od and dir all unchanged.
  - COLD: io_oe=0 currently.
  - HOT: io_oe=1 currently and any of oe/od/dir changes.
- FSM states: IDLE, PARK, WAIT_OFF, APPLY, WAIT_ON.
- FAST path:
  - io_din updates at edge k+1 (k = accept edge); state stays IDLE.
  - req_ready stays 1, giving 1 request/cycle throughput.
- HOT path:
  - IDLE->PARK: io_oe=0 at k+1.
  - WAIT_OFF holds SETTLE_CYCLES.
  - APPLY: io_od/io_dir/io_din updated at k+1+S, io_oe still 0.
  - If req_oe=1: WAIT_ON holds S cycles, then io_oe=1 at k+1+2S and return to IDLE on that edge.
  - If req_oe=0: return to IDLE at k+1+S.
- COLD path:
  - Skip PARK/WAIT_OFF; io_od/io_dir/io_din update at k+1.
  - If req_oe=1: io_oe=1 at k+1+S; otherwise IDLE at k+1.
- Output ordering:
  - io_oe never rises on the same edge that io_dir or io_od changes.
  - io_dir/io_od never change while io_oe=1.
- busy/req_ready:
  - Registered; busy=1 from edge k+1 through the final edge of a non-FAST sequence.
  - req_ready=1 in the cycle after the final edge.
- Counter: loaded with S-1 on entering a WAIT state, decrements to 0, then exits; never wraps.
- pin_in: 2-cycle latency from io_dout; runs regardless of FSM state.

Decomposition:
- Package iobuf_pkg:
  - state enum (IDLE, PARK, WAIT_OFF, APPLY, WAIT_ON)
  - packed struct io_cfg_t {oe, od, dir, din}
  - localparam for the legal SETTLE_CYCLES range
- Sub-module sync2: 2-flop synchroniser, async active-low reset to 0; used for pin_in.

Test Plan (SETTLE_CYCLES=4):
- Reset release, then request {oe=1,od=0,dir=1,din=1} at edge 0 (COLD):
  - io_dir=1, io_din=1 at edge 1; io_oe=1 at edge 5.
  - busy high edges 1..5; req_ready=1 after.
- From enabled dir=1, request {1,0,0,0} (HOT):
  - io_oe=0 at edge 1; io_dir=0 at edge 5; io_oe=1 at edge 9.
  - Checker: io_oe=0 at every edge where io_dir changes.
- FAST burst: enabled push-pull, 4 back-to-back requests toggling din 0/1/0/1:
  - io_din follows with 1-cycle latency, req_ready never drops, io_oe stays 1.
- od change while enabled, {1,1,0,1}: HOT sequence, io_od changes only at edge 5 with io_oe=0.
- Disable request {0,0,0,0} from enabled: io_oe=0 at edge 1; other outputs updated at edge 5; idle at edge 5.
- rst asserted at edge 3 of a HOT sequence:
  - all io_* = 0 immediately (before next clk), req_ready=1 after release.
  - Separately, an io_dout toggle appears on pin_in exactly 2 edges later.
